time_of_day_counter: RTL
========================

// Module: time_of_day_counter
// PURPOSE
// - Consumes the divided 1 Hz square wave i_clk from the clock divider and keeps a 24-hour time of day (hh:mm:ss).
// - Runs entirely in the clk50M domain; i_clk is treated as a data input, synchronised and rising-edge detected.
// - Provides a synchronous time-set strobe for the host/keypad logic and binary outputs for the display stage.
// PARAMETERS
// - SYNC_STAGES  2   flops in the i_clk synchroniser (min 2)
// - ALARM_LEN    30  seconds alarm_out stays high if not acknowledged (ALARM_EN only)
// PORTS
// - clk50M     in   1  system clock, 50 MHz
// - rst        in   1  asynchronous reset, active-high
// - i_clk      in   1  1 Hz square wave from the clock divider (asynchronous to counter logic)
// - run        in   1  1 = count seconds, 0 = hold time (ticks are discarded, not queued)
// - set_stb    in   1  one-cycle strobe: load set_hour/set_min/set_sec
// - set_hour   in   5  0..23
// - set_min    in   6  0..59
// - set_sec    in   6  0..59
// - hour       out  5  current hour, binary
// - min        out  6  current minute, binary
// - sec        out  6  current second, binary
// - tick_1s    out  1  one-cycle pulse on the cycle sec/min/hour change due to a tick
// - day_wrap   out  1  one-cycle pulse coincident with the 23:59:59 -> 00:00:00 tick
// - set_err    out  1  one-cycle pulse: set_stb carried an out-of-range field
// BEHAVIOUR
// - Reset (async assert, sync release): hour=min=sec=0; tick_1s=day_wrap=set_err=0; synchroniser flops=0.
// - Edge detect: i_clk -> SYNC_STAGES flops -> 1 delay flop; edge = last sync & ~delay.
// - Latency: with SYNC_STAGES=2, sec changes on the 3rd clk50M rising edge after i_clk rises; tick_1s high in that same cycle.
// - Falling edges of i_clk are ignored; exactly one increment per i_clk period.
// - Counting (edge & run & ~set_stb): sec+1; sec 59 -> 0 with min+1; min 59 -> 0 with hour+1; hour 23 -> 0 with day_wrap=1.
// - All arithmetic in field width; fields never hold out-of-range values (no 60, no 24).
// - Set: on set_stb, if set_hour<=23 and set_min<=59 and set_sec<=59, all three fields load on the next edge; else time unchanged and set_err=1 for one cycle.
// - Set and tick in same cycle: set wins; the tick is dropped (no tick_1s, no increment) whether or not the set is valid.
// - run=0: edges still tracked by synchroniser but discarded; run rising does not produce a catch-up tick.
// - Reset mid-count: outputs return to 0 immediately; first tick after release requires a fresh i_clk rising edge past the synchroniser.
// - Glitch-free outputs: hour/min/sec are registered and all change in the same cycle.
// CONFIGURATION
// - TOD_ALARM_EN defined: adds ports alarm_hour(in,5), alarm_min(in,6), alarm_arm(in,1), alarm_ack(in,1), alarm_out(out,1).
//   - alarm_out sets on the tick that makes time == alarm_hour:alarm_min:00 while alarm_arm=1.
//   - Clears on alarm_ack (next cycle), on alarm_arm=0, or after ALARM_LEN further ticks; reset value 0.
//   - A set_stb that loads exactly the alarm time does not fire the alarm (tick-triggered only).
// - TOD_ALARM_EN undefined: no alarm ports, logic or counters; all other behaviour identical.
// TESTING
// - Reset then 5 i_clk rising edges, run=1 -> sec=5, min=0, hour=0; 5 tick_1s pulses, each 3 cycles after its i_clk rise.
// - set 23:59:58, then 2 ticks -> 23:59:59 then 00:00:00; day_wrap pulses once with the second tick.
// - set_stb with set_min=60 (hour=12, sec=0) -> set_err=1 for 1 cycle, time unchanged.
// - set_stb 10:20:30 in the exact cycle edge is high -> time=10:20:30, tick_1s stays 0, no later increment.
// - run=0 across 3 i_clk edges at 01:02:03 -> stays 01:02:03; run=1 plus 1 edge -> 01:02:04.
// - TOD_ALARM_EN: alarm 06:30, armed, set 06:29:59, 1 tick -> alarm_out=1; alarm_ack -> 0 next cycle; unacked -> 0 after 30 ticks.

Source files
------------

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour hh:mm:ss counter advanced by a slow external
// square wave (i_clk) that is synchronised and rising-edge detected inside
// the clk50M domain. Host logic can load a time with set_stb.
// Optional alarm (ports alarm_hour/alarm_min/alarm_arm/alarm_ack/alarm_out)
// is compiled in when the macro TOD_ALARM_EN is defined.
module time_of_day_counter #(
  parameter int SYNC_STAGES = 2
`ifdef TOD_ALARM_EN
  ,
  parameter int ALARM_LEN   = 30
`endif
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic       i_clk,
  input  logic       run,
  input  logic       set_stb,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
`ifdef TOD_ALARM_EN
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm_out,
`endif
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       tick_1s,
  output logic       day_wrap,
  output logic       set_err
);

  // A synchroniser shorter than two flops is not safe; clamp it.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0] sync_q, sync_d;
  logic              delay_q, delay_d;
  logic [4:0]        hour_q, hour_d;
  logic [5:0]        min_q, min_d;
  logic [5:0]        sec_q, sec_d;
  logic              tick_q, tick_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;
  logic              iclk_rise;
  logic              set_ok;
  logic              count_en;

`ifdef TOD_ALARM_EN
  localparam int ACW = $clog2(ALARM_LEN + 1);
  logic           alarm_q, alarm_d;
  logic [ACW-1:0] acnt_q, acnt_d;
`endif

  // Shift i_clk through the synchroniser, then one delay flop for edge detect.
  always_comb begin
    sync_d  = {sync_q[SYNC_N-2:0], i_clk};
    delay_d = sync_q[SYNC_N-1];
  end

  assign iclk_rise = sync_q[SYNC_N-1] & ~delay_q;
  assign set_ok    = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
  // A set in the same cycle as a tick swallows the tick.
  assign count_en  = iclk_rise & run & ~set_stb;

  // Next time-of-day: load on a valid set, otherwise advance with carries on a tick.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (set_stb) begin
      if (set_ok) begin
        hour_d = set_hour;
        min_d  = set_min;
        sec_d  = set_sec;
      end else begin
        err_d = 1'b1;
      end
    end else if (count_en) begin
      tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d = 5'd0;
            wrap_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

`ifdef TOD_ALARM_EN
  // Alarm fires only when a tick lands on hh:mm:00; it then lasts until ack,
  // disarm, or ALARM_LEN further ticks.
  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (!alarm_arm || alarm_ack) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (count_en && hour_d == alarm_hour && min_d == alarm_min && sec_d == 6'd0) begin
      alarm_d = 1'b1;
      acnt_d  = '0;
    end else if (alarm_q && count_en) begin
      if (acnt_q == ACW'(ALARM_LEN - 1)) begin
        alarm_d = 1'b0;
        acnt_d  = '0;
      end else begin
        acnt_d = acnt_q + ACW'(1);
      end
    end
  end

  // Alarm state registers.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign alarm_out = alarm_q;
`endif

  // Synchroniser, time fields and one-cycle status pulses.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      delay_q <= delay_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign tick_1s  = tick_q;
  assign day_wrap = wrap_q;
  assign set_err  = err_q;

endmodule
